seg_scan_driver: RTL and testbench

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

---
 rtl/seg_scan_driver.sv | 121 ++++++++++++
 tb/tb_seg_scan_driver.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed driver for a 4-digit, common-anode,
// 7-segment display, with leading-zero blanking.
//
// Ports:
//   clk, rst       clock; asynchronous active-high reset
//   digits[15:0]   four BCD digits, [3:0] = digit 0 (rightmost)
//   dp[3:0]        decimal-point request per digit (1 = lit)
//   load           capture digits/dp into the shadow register
//   blank_lz       enable leading-zero blanking (combinational, not stored)
//   seg_n[6:0]     segments a..g on bits [0]..[6], active-low, registered
//   dp_n           decimal-point segment, active-low, registered
//   an_n[3:0]      digit enables, active-low, registered
//   frame          one-cycle pulse after the scan wraps from digit 3 to 0
module seg_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  dp,
  input  logic        load,
  input  logic        blank_lz,
  output logic [6:0]  seg_n,
  output logic        dp_n,
  output logic [3:0]  an_n,
  output logic        frame
);

  localparam logic [15:0] LAST = 16'(SCAN_DIV - 1);

  logic [15:0] cnt;
  logic        tick;
  logic [1:0]  idx;
  logic [15:0] sh_dig;
  logic [3:0]  sh_dp;

  assign tick = (cnt == LAST);

  // Active-high gfedcba pattern; non-BCD codes show a dash.
  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b0111111;
      4'd1:    decode = 7'b0000110;
      4'd2:    decode = 7'b1011011;
      4'd3:    decode = 7'b1001111;
      4'd4:    decode = 7'b1100110;
      4'd5:    decode = 7'b1101101;
      4'd6:    decode = 7'b1111101;
      4'd7:    decode = 7'b0000111;
      4'd8:    decode = 7'b1111111;
      4'd9:    decode = 7'b1101111;
      default: decode = 7'b1000000;
    endcase
  endfunction

  // A digit is a leading zero when it and every digit to its left are zero.
  // Digit 0 always stays lit so a zero value still shows "0".
  logic [3:1] zero;
  logic [3:0] blank;
  assign blank[0] = 1'b0;
  for (genvar g = 1; g < 4; g++) begin : g_blank
    assign zero[g]  = (sh_dig[g*4 +: 4] == 4'd0);
    assign blank[g] = &zero[3:g];
  end

  // Prescaler, scan index, frame pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      idx   <= '0;
      frame <= 1'b0;
    end else begin
      cnt   <= tick ? '0 : cnt + 16'd1;
      frame <= tick && (idx == 2'd3);
      if (tick) idx <= idx + 2'd1;
    end
  end

  // Shadow register: the display never reads digits/dp directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_dig <= '0;
      sh_dp  <= '0;
    end else if (load) begin
      sh_dig <= digits;
      sh_dp  <= dp;
    end
  end

  // Next output values from the pre-edge index and shadow.
  logic [3:0] cur;
  logic [6:0] seg_d;
  logic       dp_d;
  logic [3:0] an_d;

  assign cur = sh_dig[{idx, 2'b00} +: 4];

  always_comb begin
    seg_d = ~decode(cur);
    dp_d  = ~sh_dp[idx];
    an_d  = ~(4'b0001 << idx);
    if (blank_lz && blank[idx]) begin
      seg_d = 7'h7F;
      dp_d  = 1'b1;
      an_d  = 4'hF;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg_n <= 7'h7F;
      dp_n  <= 1'b1;
      an_n  <= 4'hF;
    end else begin
      seg_n <= seg_d;
      dp_n  <= dp_d;
      an_n  <= an_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed testbench for seg_scan_driver with SCAN_DIV=4.
// After the load cycle E1, the output register after edge Ek shows
// slot ((k-1)/4)%4; frame is high after every 16th edge.
module tb_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] digits = '0;
  logic [3:0]  dp = '0;
  logic        load = 1'b0;
  logic        blank_lz = 1'b0;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic [3:0]  an_n;
  logic        frame;

  int checks = 0;
  int errors = 0;

  seg_scan_driver #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .digits(digits), .dp(dp), .load(load),
    .blank_lz(blank_lz), .seg_n(seg_n), .dp_n(dp_n), .an_n(an_n),
    .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Reset, then load d/p on edge E1.
  task automatic start(input logic [15:0] d, input logic [3:0] p);
    do_reset();
    digits = d;
    dp     = p;
    load   = 1'b1;
    step();
    load   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    checks++;
    if ({seg_n, dp_n, an_n, frame} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL reset_hold: seg_n=%h dp_n=%b an_n=%h frame=%b, want 7f 1 f 0",
               seg_n, dp_n, an_n, frame);
    end
    rst = 1'b0;
    // E1..E4 show digit 0 of the zero shadow; slot 1 appears after E5.
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if ({seg_n, dp_n, an_n} !== {7'h40, 1'b1, (k == 5) ? 4'hD : 4'hE}) begin
        errors++;
        $display("FAIL reset_release E%0d: seg_n=%h dp_n=%b an_n=%h, want 40 1 %h",
                 k, seg_n, dp_n, an_n, (k == 5) ? 4'hD : 4'hE);
      end
    end
  endtask

  task automatic test_scan();
    logic [3:0][6:0] es = {7'h79, 7'h24, 7'h30, 7'h19};
    logic [3:0][3:0] ea = {4'h7, 4'hB, 4'hD, 4'hE};
    logic [3:0]      ed = 4'b1101;
    int i;
    int pulses = 0;
    start(16'h1234, 4'b0010);
    for (int k = 2; k <= 33; k++) begin
      step();
      i = ((k - 1) / 4) % 4;
      checks++;
      if ({seg_n, dp_n, an_n, frame} !== {es[i], ed[i], ea[i], (k % 16) == 0}) begin
        errors++;
        $display("FAIL scan E%0d: seg_n=%h dp_n=%b an_n=%h frame=%b, want %h %b %h %b",
                 k, seg_n, dp_n, an_n, frame, es[i], ed[i], ea[i], (k % 16) == 0);
      end
      if (frame) pulses++;
    end
    checks++;
    if (pulses !== 2) begin
      errors++;
      $display("FAIL frame_count: got %0d pulses, want 2", pulses);
    end
  endtask

  task automatic test_decode();
    logic [3:0][6:0] es = {7'h00, 7'h78, 7'h02, 7'h12};
    int i;
    start(16'h8765, 4'b0000);
    for (int k = 2; k <= 17; k++) begin
      step();
      i = ((k - 1) / 4) % 4;
      checks++;
      if (seg_n !== es[i]) begin
        errors++;
        $display("FAIL decode E%0d: seg_n=%h, want %h", k, seg_n, es[i]);
      end
    end
  endtask

  // dp set on a blanked digit must stay dark.
  task automatic test_blank();
    logic [3:0][6:0] es = {7'h7F, 7'h7F, 7'h12, 7'h40};
    logic [3:0][3:0] ea = {4'hF, 4'hF, 4'hD, 4'hE};
    int i;
    blank_lz = 1'b1;
    start(16'h0050, 4'b1000);
    for (int k = 2; k <= 17; k++) begin
      step();
      i = ((k - 1) / 4) % 4;
      checks++;
      if ({seg_n, dp_n, an_n} !== {es[i], 1'b1, ea[i]}) begin
        errors++;
        $display("FAIL blank E%0d: seg_n=%h dp_n=%b an_n=%h, want %h 1 %h",
                 k, seg_n, dp_n, an_n, es[i], ea[i]);
      end
    end
    blank_lz = 1'b0;
  endtask

  task automatic test_zero();
    logic [3:0][3:0] ea = {4'h7, 4'hB, 4'hD, 4'hE};
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    int i;
    blank_lz = 1'b1;
    start(16'h0000, 4'b0000);
    for (int k = 2; k <= 33; k++) begin
      if (k == 18) blank_lz = 1'b0;
      step();
      i = ((k - 1) / 4) % 4;
      exp_an  = (k < 18 && i != 0) ? 4'hF : ea[i];
      exp_seg = (k < 18 && i != 0) ? 7'h7F : 7'h40;
      checks++;
      if ({seg_n, an_n} !== {exp_seg, exp_an}) begin
        errors++;
        $display("FAIL zero E%0d: seg_n=%h an_n=%h, want %h %h",
                 k, seg_n, an_n, exp_seg, exp_an);
      end
    end
  endtask

  task automatic test_dash();
    logic [3:0][6:0] es = {7'h40, 7'h40, 7'h3F, 7'h3F};
    logic [3:0][3:0] ea = {4'h7, 4'hB, 4'hD, 4'hE};
    logic [3:0]      ed = 4'b0110;
    int i;
    start(16'h00AF, 4'b1001);
    for (int k = 2; k <= 17; k++) begin
      step();
      i = ((k - 1) / 4) % 4;
      checks++;
      if ({seg_n, dp_n, an_n} !== {es[i], ed[i], ea[i]}) begin
        errors++;
        $display("FAIL dash E%0d: seg_n=%h dp_n=%b an_n=%h, want %h %b %h",
                 k, seg_n, dp_n, an_n, es[i], ed[i], ea[i]);
      end
    end
  endtask

  // Load on the tick edge E4: E4 still shows the old digit, E5 on shows 9.
  task automatic test_back_to_back();
    logic [3:0] exp_an;
    start(16'h1234, 4'b0000);
    step();
    step();
    digits = 16'h9999;
    load   = 1'b1;
    step();
    load   = 1'b0;
    digits = 16'h5555;
    checks++;
    if ({seg_n, an_n} !== {7'h19, 4'hE}) begin
      errors++;
      $display("FAIL load_tick_old: seg_n=%h an_n=%h, want 19 e", seg_n, an_n);
    end
    for (int k = 5; k <= 12; k++) begin
      step();
      exp_an = (k <= 8) ? 4'hD : 4'hB;
      checks++;
      if ({seg_n, an_n} !== {7'h10, exp_an}) begin
        errors++;
        $display("FAIL load_tick_new E%0d: seg_n=%h an_n=%h, want 10 %h",
                 k, seg_n, an_n, exp_an);
      end
    end
  endtask

  task automatic test_async_reset();
    int seen = 0;
    start(16'h1234, 4'b0100);
    for (int k = 2; k <= 10; k++) step();
    checks++;
    if (an_n !== 4'hB) begin
      errors++;
      $display("FAIL midframe_setup: an_n=%h, want b", an_n);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({seg_n, dp_n, an_n, frame} !== {7'h7F, 1'b1, 4'hF, 1'b0}) begin
      errors++;
      $display("FAIL async_reset: seg_n=%h dp_n=%b an_n=%h frame=%b, want 7f 1 f 0",
               seg_n, dp_n, an_n, frame);
    end
    step();
    rst = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      step();
      if (frame) seen++;
      checks++;
      if ({seg_n, an_n} !== {7'h40, (k <= 4) ? 4'hE : (k <= 8) ? 4'hD : (k <= 12) ? 4'hB : 4'h7}) begin
        errors++;
        $display("FAIL restart F%0d: seg_n=%h an_n=%h", k, seg_n, an_n);
      end
    end
    checks++;
    if (seen !== 0) begin
      errors++;
      $display("FAIL no_frame_after_reset: got %0d pulses, want 0", seen);
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_decode();
    test_blank();
    test_zero();
    test_dash();
    test_back_to_back();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
